// File: rtl/avalon_rsa_mem_if.sv
// Avalon-MM bus between the RSA accelerator m0 master and its memory target.
interface avalon_rsa_mem_if #(parameter int DATA_W = 256);
  logic [31:0]       avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/avalon_rsa_mem_slave.sv
// On-chip Avalon-MM memory target for the RSA m0 port: fixed-latency pipelined
// reads, zero-latency writes, waitrequest backpressure, sticky protocol error.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | zeroing the array one word per cycle, waitrequest held high
//   ST_RUN  | serving requests, waitrequest = stall | pending full
module avalon_rsa_mem_slave #(
  parameter int DATA_W       = 256,
  parameter int DEPTH_LOG2   = 6,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  avalon_rsa_mem_if.slave         avs,
  input  logic                    stall,
  output logic [15:0]             wr_count,
  output logic [15:0]             rd_count,
  output logic                    err
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state, state_nxt;
  logic [DEPTH_LOG2-1:0]   init_cnt, init_cnt_nxt;
  logic                    waitreq;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    oor, misalign, accept;
  logic                    wr_fire, wr_land, rd_fire, proto_err;
  logic [DATA_W-1:0]       rd_word;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [DATA_W-1:0]       pipe_data [READ_LATENCY];
  logic                    ret;
  logic [PEND_W-1:0]       pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_cnt <= DEPTH_LOG2'(DEPTH - 1);
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    waitreq      = 1'b1;
    case (state)
      ST_INIT: begin
        init_cnt_nxt = init_cnt - 1'b1;
        if (init_cnt == '0) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        waitreq = stall | (pending >= PEND_MAX);
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign idx       = avs.avs_address[DEPTH_LOG2+4:5];
  assign oor       = |avs.avs_address[31:DEPTH_LOG2+5];
  assign misalign  = |avs.avs_address[4:0];
  assign accept    = (avs.avs_read | avs.avs_write) & ~waitreq;
  assign wr_fire   = accept & avs.avs_write;
  assign wr_land   = wr_fire & ~oor;
  // a read issued together with a write is dropped; the write wins
  assign rd_fire   = accept & avs.avs_read & ~avs.avs_write;
  assign proto_err = accept & ((avs.avs_read & avs.avs_write) | oor | misalign);
  assign rd_word   = oor ? '0 : mem[idx];

  always_ff @(posedge clk) begin
    if (state == ST_INIT) mem[init_cnt] <= '0;
    else if (wr_land)     mem[idx]      <= avs.avs_writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_fire;
      if (rd_fire) pipe_data[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  // ret marks the edge that loads the output stage, so the slot frees early
  // enough to sustain one read per cycle when MAX_PENDING >= READ_LATENCY
  generate
    if (READ_LATENCY == 1) begin : g_ret_l1
      assign ret = rd_fire;
    end else begin : g_ret_ln
      assign ret = pipe_vld[READ_LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      wr_count <= '0;
      rd_count <= '0;
      err      <= 1'b0;
    end else begin
      case ({rd_fire, ret})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
      if (wr_land && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (ret && rd_count != 16'hFFFF)     rd_count <= rd_count + 16'd1;
      if (proto_err)                       err      <= 1'b1;
    end
  end

  assign avs.avs_waitrequest   = waitreq;
  assign avs.avs_readdata      = pipe_data[READ_LATENCY-1];
  assign avs.avs_readdatavalid = pipe_vld[READ_LATENCY-1];

endmodule
